addsub_acc_ctrl: RTL and testbench
==================================

// Module: addsub_acc_ctrl
// PURPOSE
//  Sequencing/accumulator stage wrapped around the combinational 4-bit adder-subtractor.
//  - Upstream: accepts operations over a valid/ready handshake.
//  - Adder side: drives the operands and the mode bit M, then registers the adder's S/C/V.
//  - Accumulator: holds the running result and feeds it back as operand A.
//  - Downstream: presents a registered result plus flags on a second valid/ready handshake.
// PARAMETERS
//  WIDTH  4  datapath width. Must equal the adder width; the integrator bit-maps the vectors onto a0..a3/b0..b3/S0..S3.
// PORTS
//  clk         in   1      single clock, rising edge
//  rst_n       in   1      synchronous reset, active low
//  in_valid    in   1      operation request valid
//  in_ready    out  1      block can accept an operation
//  in_op       in   2      00 ADD, 01 SUB, 10 LOAD, 11 CLEAR
//  in_b        in   WIDTH  operand B (LOAD value for LOAD)
//  add_m       out  1      adder mode M: 0 add, 1 subtract
//  add_a       out  WIDTH  adder operand A (always = accumulator)
//  add_b       out  WIDTH  adder operand B (registered in_b)
//  add_s       in   WIDTH  adder sum
//  add_c       in   1      adder carry-out
//  add_v       in   1      adder overflow
//  out_valid   out  1      result valid
//  out_ready   in   1      consumer accepts result
//  out_acc     out  WIDTH  accumulator value after the operation
//  out_c       out  1      carry; for SUB, 1 = no borrow
//  out_v       out  1      signed overflow of this operation
//  out_z       out  1      out_acc == 0
//  ovf_sticky  out  1      sticky overflow flag
//  sticky_clr  in   1      clears ovf_sticky
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge):
//  - state<=IDLE; acc, op_q, b_q, out_acc, out_c, out_v, ovf_sticky <= 0; out_valid <= 0.
//  - Resulting outputs: out_z=1, in_ready=1, add_m=0.
//  - Reset in any state aborts the operation in flight; no out_valid is produced for it.
//  FSM IDLE -> EXEC -> RESP -> IDLE:
//  - IDLE: in_ready=1. On in_valid&in_ready, capture in_op/in_b and go to EXEC.
//  - EXEC: in_ready=0, exactly 1 cycle. add_m=op_q[0], add_a=acc, add_b=b_q, all stable for the whole cycle.
//    At the end of EXEC, update acc and out_* and go to RESP:
//    - ADD/SUB: acc<=add_s; out_c<=add_c; out_v<=add_v.
//    - LOAD: acc<=b_q; out_c<=0; out_v<=0. Adder outputs are ignored.
//    - CLEAR: acc<=0; out_c<=0; out_v<=0.
//  - RESP: out_valid=1. out_acc=acc; out_z=(acc==0).
//    - All out_* hold stable while out_ready=0.
//    - On out_ready, go to IDLE.
//  Latency and throughput:
//  - Accept at edge k -> out_valid=1 from edge k+2.
//  - Next accept no earlier than 1 cycle after the out handshake. Max throughput: 1 op per 3 cycles.
//  - in_ready=0 outside IDLE; no request queuing.
//  Arithmetic:
//  - Two's-complement, mod 2^WIDTH. The adder does all arithmetic; the block does no arithmetic of its own, except for saturation (see CONFIGURATION).
//  ovf_sticky:
//  - Set at the end of EXEC of ADD/SUB when add_v=1. Cleared when sticky_clr=1.
//  - Set and clear in the same cycle -> set wins.
//  - LOAD and CLEAR do not affect it.
//  - Unknown or undriven adder inputs are never sampled outside EXEC.
// CONFIGURATION
//  ACC_SAT_EN defined: saturation applies to ADD/SUB when add_v=1.
//  - acc<=0111..1 if add_a MSB=0; acc<=1000..0 if add_a MSB=1.
//  - out_v and ovf_sticky still report the overflow.
//  - out_c is still the raw add_c.
//  ACC_SAT_EN undefined: wrap-around; acc<=add_s unconditionally.
// TESTING (WIDTH=4; bench uses a behavioural adder model)
//  1. Reset, LOAD 0101 -> out_valid 2 cycles after accept; out_acc=0101, c=0, v=0, z=0.
//  2. acc=0101, ADD 0011 -> out_acc=1000, c=0, v=1, ovf_sticky=1.
//     With ACC_SAT_EN defined, same stimulus -> out_acc=0111, v=1.
//  3. acc=0101, SUB 0101 -> add_m=1 during EXEC; out_acc=0000, c=1, v=0, z=1.
//  4. out_ready=0 for 3 cycles in RESP -> out_* stable, in_ready=0.
//     Then handshake -> in_ready=1 the next cycle; a new request is accepted.
//  5. sticky_clr=1 in the same EXEC cycle that overflows -> ovf_sticky=1.
//     sticky_clr pulsed later -> ovf_sticky=0.
//  6. rst_n=0 during EXEC -> next cycle: IDLE, acc=0, out_valid=0, in_ready=1, ovf_sticky=0.

Source files
------------

// File: rtl/addsub_acc_ctrl.sv
// addsub_acc_ctrl: sequencing and accumulator stage around an external
// combinational WIDTH-bit adder-subtractor. Requests are accepted over a
// valid/ready handshake, executed against the adder for exactly one cycle,
// and the registered result is presented on a second valid/ready handshake.
// Optional feature: define ACC_SAT_EN to saturate the accumulator on signed
// overflow of ADD/SUB instead of wrapping around.
module addsub_acc_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_b,
  output logic             add_m,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_c,
  input  logic             add_v,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_acc,
  output logic             out_c,
  output logic             out_v,
  output logic             out_z,
  output logic             ovf_sticky,
  input  logic             sticky_clr
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic [1:0]              state;
  logic [1:0]              op_q;
  logic [WIDTH-1:0]        b_q;
  logic signed [WIDTH-1:0] acc;
  logic signed [WIDTH-1:0] acc_next;
  logic                    c_next;
  logic                    v_next;
  logic                    is_arith;

  // Saturation limit chosen by the sign of operand A: an overflow can only
  // push the result past the extreme on the same side as A.
  function automatic logic signed [WIDTH-1:0] sat_limit(input logic a_neg);
    logic signed [WIDTH-1:0] lim;
    lim = a_neg ? $signed({1'b1, {(WIDTH-1){1'b0}}})
                : $signed({1'b0, {(WIDTH-1){1'b1}}});
    return lim;
  endfunction

  assign is_arith   = ~op_q[1];
  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == RESP);
  assign add_m      = op_q[0];
  assign add_a      = acc;
  assign add_b      = b_q;
  assign out_acc    = acc;
  assign out_z      = (acc == '0);

  // Next accumulator value and flags for the operation held in op_q.
  always_comb begin
    acc_next = acc;
    c_next   = 1'b0;
    v_next   = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: begin
        acc_next = $signed(add_s);
        c_next   = add_c;
        v_next   = add_v;
`ifdef ACC_SAT_EN
        if (add_v) acc_next = sat_limit(acc[WIDTH-1]);
`endif
      end
      OP_LOAD:  acc_next = $signed(b_q);
      OP_CLEAR: acc_next = '0;
      default:  acc_next = '0;
    endcase
  end

  // Control FSM with request capture and end-of-EXEC result registration.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      op_q  <= '0;
      b_q   <= '0;
      acc   <= '0;
      out_c <= 1'b0;
      out_v <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q  <= in_op;
            b_q   <= in_b;
            state <= EXEC;
          end
        end
        EXEC: begin
          acc   <= acc_next;
          out_c <= c_next;
          out_v <= v_next;
          state <= RESP;
        end
        RESP: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky overflow: an overflow in EXEC takes priority over a clear request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
    end else if (state == EXEC && is_arith && add_v) begin
      ovf_sticky <= 1'b1;
    end else if (sticky_clr) begin
      ovf_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_addsub_acc_ctrl.sv
// Testbench for addsub_acc_ctrl with a behavioural 4-bit adder-subtractor.
// Directed requests push hand-computed results into a scoreboard queue; a
// monitor pops and compares on every output handshake.
module tb_addsub_acc_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_op;
  logic [W-1:0] in_b;
  logic         add_m;
  logic [W-1:0] add_a;
  logic [W-1:0] add_b;
  logic [W-1:0] add_s;
  logic         add_c;
  logic         add_v;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_acc;
  logic         out_c;
  logic         out_v;
  logic         out_z;
  logic         ovf_sticky;
  logic         sticky_clr;

  typedef struct {
    logic [W-1:0] acc;
    logic         c;
    logic         v;
    logic         z;
    logic         s;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  addsub_acc_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_b(in_b),
    .add_m(add_m), .add_a(add_a), .add_b(add_b),
    .add_s(add_s), .add_c(add_c), .add_v(add_v),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_c(out_c), .out_v(out_v), .out_z(out_z),
    .ovf_sticky(ovf_sticky), .sticky_clr(sticky_clr)
  );

  // Behavioural adder-subtractor: S = A + (B xor M) + M.
  logic [W-1:0] bb;
  logic [W:0]   sum5;
  always_comb begin
    bb    = add_m ? ~add_b : add_b;
    sum5  = {1'b0, add_a} + {1'b0, bb} + {{W{1'b0}}, add_m};
    add_s = sum5[W-1:0];
    add_c = sum5[W];
    add_v = (add_a[W-1] == bb[W-1]) && (add_s[W-1] != add_a[W-1]);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [W-1:0] acc, input logic c,
                          input logic v, input logic s);
    exp_t e;
    e.acc = acc; e.c = c; e.v = v; e.z = (acc == '0); e.s = s;
    sbq.push_back(e);
  endtask

  // Wait for in_ready, then present one request for a single accepting edge.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] b);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("issue_timeout", 0, 1);
    in_valid = 1'b1;
    in_op    = op;
    in_b     = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Wait for the response to be presented and let its handshake complete.
  task automatic finish_resp();
    int t = 0;
    while (!out_valid && t < 10) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) chk("resp_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    sticky_clr = 1'b1;
    @(posedge clk);
    #1 sticky_clr = 1'b0;
  endtask

  // Scoreboard monitor: compare every accepted result against the queue head.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("out_acc", out_acc, e.acc);
        chk("out_c", out_c, e.c);
        chk("out_v", out_v, e.v);
        chk("out_z", out_z, e.z);
        chk("ovf_sticky", ovf_sticky, e.s);
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_b = '0;
    out_ready = 1'b1; sticky_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_z", out_z, 1);
    chk("rst_add_m", add_m, 0);
    chk("rst_out_acc", out_acc, 0);
    chk("rst_sticky", ovf_sticky, 0);

    // LOAD 0101 with latency check
    push_exp(4'b0101, 0, 0, 0);
    issue(2'b10, 4'b0101);
    @(negedge clk);
    chk("t1_exec_out_valid", out_valid, 0);
    chk("t1_exec_in_ready", in_ready, 0);
    @(negedge clk);
    chk("t1_resp_out_valid", out_valid, 1);
    finish_resp();

    // ADD 0011 overflows
`ifdef ACC_SAT_EN
    push_exp(4'b0111, 0, 1, 1);
`else
    push_exp(4'b1000, 0, 1, 1);
`endif
    issue(2'b00, 4'b0011);
    finish_resp();

    // Reload 0101, then SUB 0101 -> zero, no borrow
    push_exp(4'b0101, 0, 0, 1);
    issue(2'b10, 4'b0101);
    finish_resp();
    push_exp(4'b0000, 1, 0, 1);
    issue(2'b01, 4'b0101);
    @(negedge clk);
    chk("t3_add_m", add_m, 1);
    chk("t3_add_a", add_a, 5);
    chk("t3_add_b", add_b, 5);
    finish_resp();

    pulse_clr();
    @(negedge clk);
    chk("clr_sticky", ovf_sticky, 0);

    // Back-pressure: LOAD 0011 held in RESP for 3 cycles
    out_ready = 1'b0;
    push_exp(4'b0011, 0, 0, 0);
    issue(2'b10, 4'b0011);
    begin
      int t = 0;
      while (!out_valid && t < 10) begin
        @(negedge clk);
        t++;
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_acc", out_acc, 3);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("post_hs_in_ready", in_ready, 1);
    chk("post_hs_out_valid", out_valid, 0);

    // ADD 1110 (-2): 3 + -2 = 1 with carry
    push_exp(4'b0001, 1, 0, 0);
    issue(2'b00, 4'b1110);
    finish_resp();

    // LOAD 0111, ADD 0001 overflows with sticky_clr in the same EXEC cycle
    push_exp(4'b0111, 0, 0, 0);
    issue(2'b10, 4'b0111);
    finish_resp();
`ifdef ACC_SAT_EN
    push_exp(4'b0111, 0, 1, 1);
`else
    push_exp(4'b1000, 0, 1, 1);
`endif
    issue(2'b00, 4'b0001);
    sticky_clr = 1'b1;
    @(posedge clk);
    #1 sticky_clr = 1'b0;
    finish_resp();
    pulse_clr();
    @(negedge clk);
    chk("t5_sticky_cleared", ovf_sticky, 0);

    // LOAD 1000, SUB 0001: negative overflow
    push_exp(4'b1000, 0, 0, 0);
    issue(2'b10, 4'b1000);
    finish_resp();
`ifdef ACC_SAT_EN
    push_exp(4'b1000, 1, 1, 1);
`else
    push_exp(4'b0111, 1, 1, 1);
`endif
    issue(2'b01, 4'b0001);
    finish_resp();

    // CLEAR leaves sticky untouched and zeroes flags
    push_exp(4'b0000, 0, 0, 1);
    issue(2'b11, 4'b0000);
    finish_resp();

    // Reset during EXEC aborts the operation
    issue(2'b10, 4'b0110);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t6_in_ready", in_ready, 1);
    chk("t6_out_valid", out_valid, 0);
    chk("t6_out_acc", out_acc, 0);
    chk("t6_sticky", ovf_sticky, 0);
    chk("t6_out_z", out_z, 1);

    push_exp(4'b0001, 0, 0, 0);
    issue(2'b00, 4'b0001);
    finish_resp();

    repeat (3) @(negedge clk);
    chk("sb_drain", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
